// File: rtl/frame_arbiter.sv
// Two-source AXI-Stream frame arbiter. Grants one source per frame with
// round-robin fairness, forwards beats combinationally while a frame is
// granted, and truncates frames longer than MAX_BEATS (forced TLAST), then
// silently drains the remainder of the oversized frame from its source.
module frame_arbiter #(
    parameter int DATA_W    = 4,
    parameter int USER_W    = 2,
    parameter int MAX_BEATS = 64,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,

    input  logic [DATA_W-1:0] s0_TDATA,
    input  logic [USER_W-1:0] s0_TUSER,
    input  logic              s0_TLAST,
    input  logic              s0_TVALID,
    output logic              s0_TREADY,

    input  logic [DATA_W-1:0] s1_TDATA,
    input  logic [USER_W-1:0] s1_TUSER,
    input  logic              s1_TLAST,
    input  logic              s1_TVALID,
    output logic              s1_TREADY,

    output logic [DATA_W-1:0] m_TDATA,
    output logic [USER_W-1:0] m_TUSER,
    output logic              m_TLAST,
    output logic              m_TVALID,
    input  logic              m_TREADY,

    output logic              grant,
    output logic              trunc_pulse,
    output logic [CNT_W-1:0]  frame_cnt
);

    // Wide enough to count one past the limit while draining.
    localparam int BEAT_W = $clog2(MAX_BEATS + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state;
    logic                last_src;   // source served most recently
    logic [BEAT_W-1:0]   beat_cnt;

    logic [DATA_W-1:0]   sel_data;
    logic [USER_W-1:0]   sel_user;
    logic                sel_last;
    logic                sel_valid;
    logic                hs;
    logic                at_limit;
    logic                pick;

    // Frame counter increments stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Source mux, handshake qualification and round-robin pick.
    always_comb begin
        sel_data  = grant ? s1_TDATA  : s0_TDATA;
        sel_user  = grant ? s1_TUSER  : s0_TUSER;
        sel_last  = grant ? s1_TLAST  : s0_TLAST;
        sel_valid = grant ? s1_TVALID : s0_TVALID;
        at_limit  = (beat_cnt == LAST_BEAT);
        // With both requesting, the one not served last wins.
        pick      = (s0_TVALID && s1_TVALID) ? ~last_src : s1_TVALID;

        m_TDATA   = sel_data;
        m_TUSER   = sel_user;
        m_TLAST   = sel_last | at_limit;
        m_TVALID  = (state == ST_PASS) && sel_valid;
        hs        = m_TVALID && m_TREADY;

        s0_TREADY = 1'b0;
        s1_TREADY = 1'b0;
        if (state == ST_PASS) begin
            if (grant) s1_TREADY = m_TREADY;
            else       s0_TREADY = m_TREADY;
        end else if (state == ST_DRAIN) begin
            // Draining swallows the rest of the oversized frame at full rate.
            if (grant) s1_TREADY = 1'b1;
            else       s0_TREADY = 1'b1;
        end
    end

    // Arbitration FSM with its registered status outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            grant       <= 1'b0;
            last_src    <= 1'b1;
            beat_cnt    <= '0;
            frame_cnt   <= '0;
            trunc_pulse <= 1'b0;
        end else begin
            trunc_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable && (s0_TVALID || s1_TVALID)) begin
                        grant    <= pick;
                        beat_cnt <= '0;
                        state    <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (hs) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                        // A genuine end of frame wins over truncation.
                        if (sel_last) begin
                            frame_cnt <= sat_inc(frame_cnt);
                            last_src  <= grant;
                            grant     <= 1'b0;
                            state     <= ST_IDLE;
                        end else if (at_limit) begin
                            frame_cnt   <= sat_inc(frame_cnt);
                            last_src    <= grant;
                            trunc_pulse <= 1'b1;
                            state       <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (sel_valid && sel_last) begin
                        grant <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    grant <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_arbiter.sv
// Bench for frame_arbiter: bench-side sources replay queued frames, the
// master side records every accepted beat, and each test compares against
// frames predicted from the arbitration and truncation rules.
module tb_frame_arbiter;

    localparam int DW   = 4;
    localparam int UW   = 2;
    localparam int MAXB = 4;
    localparam int CW   = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic          src;
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
        logic [31:0]   cyc;
    } obs_t;

    logic          tb_clk;
    logic          resetn;
    logic          enable;
    logic [DW-1:0] s0_TDATA, s1_TDATA, m_TDATA;
    logic [UW-1:0] s0_TUSER, s1_TUSER, m_TUSER;
    logic          s0_TLAST, s1_TLAST, m_TLAST;
    logic          s0_TVALID, s1_TVALID, m_TVALID;
    logic          s0_TREADY, s1_TREADY, m_TREADY;
    logic          grant;
    logic          trunc_pulse;
    logic [CW-1:0] frame_cnt;

    frame_arbiter #(.DATA_W(DW), .USER_W(UW), .MAX_BEATS(MAXB), .CNT_W(CW)) dut (
        .clk(tb_clk), .resetn(resetn), .enable(enable),
        .s0_TDATA(s0_TDATA), .s0_TUSER(s0_TUSER), .s0_TLAST(s0_TLAST),
        .s0_TVALID(s0_TVALID), .s0_TREADY(s0_TREADY),
        .s1_TDATA(s1_TDATA), .s1_TUSER(s1_TUSER), .s1_TLAST(s1_TLAST),
        .s1_TVALID(s1_TVALID), .s1_TREADY(s1_TREADY),
        .m_TDATA(m_TDATA), .m_TUSER(m_TUSER), .m_TLAST(m_TLAST),
        .m_TVALID(m_TVALID), .m_TREADY(m_TREADY),
        .grant(grant), .trunc_pulse(trunc_pulse), .frame_cnt(frame_cnt)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    beat_t q0[$], q1[$];       // beats each source still has to deliver
    beat_t exp0[$], exp1[$];   // beats expected on m_ from each source
    obs_t  obs[$];             // beats accepted on m_
    int    n_cmp, n_fail;
    int    n_pulse, pulse_cyc;
    int    cyc;
    int    rdy_mode;           // 0: always ready, 1: toggle 1,0,1,0, 2: random
    bit    rnd_valid;

    // Queue a frame on a source and record what m_ should carry for it.
    function automatic void push_frame(input int src, input int len, input int d0,
                                       input bit rnd, input int usr);
        int keep;
        beat_t b;
        keep = (len > MAXB) ? MAXB : len;
        for (int i = 0; i < len; i++) begin
            b.data = rnd ? DW'($urandom) : DW'(d0 + i);
            b.user = rnd ? UW'($urandom) : UW'(usr);
            b.last = (i == len - 1);
            if (src == 0) q0.push_back(b); else q1.push_back(b);
            if (i < keep) begin
                b.last = (i == keep - 1);
                if (src == 0) exp0.push_back(b); else exp1.push_back(b);
            end
        end
    endfunction

    task automatic drive();
        case (rdy_mode)
            0:       m_TREADY = 1'b1;
            1:       m_TREADY = (cyc % 2 == 0);
            default: m_TREADY = 1'($urandom_range(0, 1));
        endcase
        if (q0.size() > 0) begin
            if (!s0_TVALID) s0_TVALID = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            s0_TDATA = q0[0].data; s0_TUSER = q0[0].user; s0_TLAST = q0[0].last;
        end else begin
            s0_TVALID = 1'b0; s0_TLAST = 1'b0;
        end
        if (q1.size() > 0) begin
            if (!s1_TVALID) s1_TVALID = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            s1_TDATA = q1[0].data; s1_TUSER = q1[0].user; s1_TLAST = q1[0].last;
        end else begin
            s1_TVALID = 1'b0; s1_TLAST = 1'b0;
        end
        #1;
    endtask

    task automatic advance();
        if (s0_TVALID && s0_TREADY && q0.size() > 0) void'(q0.pop_front());
        if (s1_TVALID && s1_TREADY && q1.size() > 0) void'(q1.pop_front());
        if (m_TVALID && m_TREADY)
            obs.push_back('{grant, m_TDATA, m_TUSER, m_TLAST, 32'(cyc)});
        if (trunc_pulse) begin
            n_pulse++;
            pulse_cyc = cyc;
        end
        @(posedge tb_clk);
        @(negedge tb_clk);
        cyc++;
    endtask

    task automatic do_reset();
        resetn = 1'b0; enable = 1'b1; rdy_mode = 0; rnd_valid = 1'b0;
        q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
        s0_TVALID = 1'b0; s1_TVALID = 1'b0;
        drive(); advance(); drive(); advance();
        resetn = 1'b1;
        obs.delete(); n_pulse = 0; pulse_cyc = -1; cyc = 0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable = 1'b1; rdy_mode = 0; rnd_valid = 1'b0;
        push_frame(0, 3, 1, 1'b0, 0);
        drive(); advance(); drive(); advance();
        drive();
        n_cmp++; if (m_TVALID !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid: got %b expected 0", m_TVALID); end
        n_cmp++; if (s0_TREADY !== 1'b0) begin n_fail++; $display("FAIL reset_s0_tready: got %b expected 0", s0_TREADY); end
        n_cmp++; if (s1_TREADY !== 1'b0) begin n_fail++; $display("FAIL reset_s1_tready: got %b expected 0", s1_TREADY); end
        n_cmp++; if (frame_cnt !== '0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        n_cmp++; if (grant !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %b expected 0", grant); end
        n_cmp++; if (trunc_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_trunc_pulse: got %b expected 0", trunc_pulse); end
        advance();
    endtask

    // Frame of exactly MAX_BEATS beats ending in its own TLAST: no truncation.
    task automatic test_single();
        int guard;
        do_reset();
        push_frame(0, 4, 1, 1'b0, 2);
        drive();
        n_cmp++; if (m_TVALID !== 1'b0 || s0_TREADY !== 1'b0) begin n_fail++;
            $display("FAIL single_idle_latency: got valid=%b ready=%b expected 0/0", m_TVALID, s0_TREADY); end
        advance();
        guard = 0;
        while (q0.size() > 0 && guard < 20) begin drive(); advance(); guard++; end
        drive();
        n_cmp++; if (obs.size() !== 4) begin n_fail++; $display("FAIL single_count: got %0d expected 4", obs.size()); end
        for (int i = 0; i < obs.size() && i < 4; i++) begin
            n_cmp++;
            if (obs[i].data !== DW'(i + 1) || obs[i].user !== UW'(2) || obs[i].last !== (i == 3) ||
                obs[i].src !== 1'b0 || obs[i].cyc !== 32'(i + 1)) begin
                n_fail++;
                $display("FAIL single_beat%0d: got d=%0d u=%0d l=%b s=%b c=%0d expected d=%0d u=2 l=%b s=0 c=%0d",
                         i, obs[i].data, obs[i].user, obs[i].last, obs[i].src, obs[i].cyc, i + 1, i == 3, i + 1);
            end
        end
        n_cmp++; if (frame_cnt !== CW'(1)) begin n_fail++; $display("FAIL single_frame_cnt: got %0d expected 1", frame_cnt); end
        n_cmp++; if (m_TVALID !== 1'b0 || grant !== 1'b0) begin n_fail++;
            $display("FAIL single_back_idle: got valid=%b grant=%b expected 0/0", m_TVALID, grant); end
        n_cmp++; if (n_pulse !== 0) begin n_fail++; $display("FAIL single_no_trunc: got %0d pulses expected 0", n_pulse); end
    endtask

    task automatic test_round_robin();
        int guard, k, b;
        do_reset();
        for (int f = 0; f < 4; f++) begin
            push_frame(0, 3, (0 << 3) | ((f & 1) << 2), 1'b0, f);
            push_frame(1, 3, (1 << 3) | ((f & 1) << 2), 1'b0, f);
        end
        guard = 0;
        while ((q0.size() > 0 || q1.size() > 0) && guard < 60) begin drive(); advance(); guard++; end
        n_cmp++; if (obs.size() !== 24) begin n_fail++; $display("FAIL rr_count: got %0d expected 24", obs.size()); end
        for (int i = 0; i < obs.size() && i < 24; i++) begin
            k = i / 3; b = i % 3;
            n_cmp++;
            if (obs[i].src !== 1'(k % 2) || obs[i].data !== DW'(((k % 2) << 3) | (((k / 2) & 1) << 2) | b) ||
                obs[i].user !== UW'(k / 2) || obs[i].last !== (b == 2)) begin
                n_fail++;
                $display("FAIL rr_beat%0d: got s=%b d=%0d u=%0d l=%b expected s=%0d d=%0d u=%0d l=%b",
                         i, obs[i].src, obs[i].data, obs[i].user, obs[i].last, k % 2,
                         ((k % 2) << 3) | (((k / 2) & 1) << 2) | b, k / 2, b == 2);
            end
            if (b == 0 && i > 0) begin
                n_cmp++;
                if (obs[i].cyc - obs[i - 1].cyc !== 32'd2) begin
                    n_fail++;
                    $display("FAIL rr_gap%0d: got %0d cycles expected 2", k, obs[i].cyc - obs[i - 1].cyc);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int guard;
        do_reset();
        rdy_mode = 1;
        push_frame(1, 4, 9, 1'b0, 1);
        guard = 0;
        while (q1.size() > 0 && guard < 30) begin
            drive();
            if (m_TVALID) begin
                n_cmp++;
                if (s1_TREADY !== m_TREADY || s0_TREADY !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_ready_mirror: got s1=%b s0=%b expected s1=%b s0=0", s1_TREADY, s0_TREADY, m_TREADY);
                end
            end
            advance(); guard++;
        end
        n_cmp++; if (obs.size() !== 4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", obs.size()); end
        for (int i = 0; i < obs.size() && i < 4; i++) begin
            n_cmp++;
            if (obs[i].data !== DW'(9 + i) || obs[i].src !== 1'b1 || obs[i].last !== (i == 3)) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got d=%0d s=%b l=%b expected d=%0d s=1 l=%b",
                         i, obs[i].data, obs[i].src, obs[i].last, 9 + i, i == 3);
            end
        end
        n_cmp++; if (frame_cnt !== CW'(1)) begin n_fail++; $display("FAIL bp_frame_cnt: got %0d expected 1", frame_cnt); end
    endtask

    task automatic test_truncation();
        int guard;
        do_reset();
        push_frame(1, 7, 1, 1'b0, 3);
        guard = 0;
        while (q1.size() > 0 && guard < 30) begin
            drive();
            if (obs.size() == 4) begin
                n_cmp++;
                if (m_TVALID !== 1'b0 || s1_TREADY !== 1'b1) begin
                    n_fail++;
                    $display("FAIL trunc_drain: got valid=%b s1_ready=%b expected 0/1", m_TVALID, s1_TREADY);
                end
            end
            advance(); guard++;
        end
        drive(); advance();
        n_cmp++; if (q1.size() !== 0) begin n_fail++; $display("FAIL trunc_drained: got %0d beats left expected 0", q1.size()); end
        n_cmp++; if (obs.size() !== 4) begin n_fail++; $display("FAIL trunc_count: got %0d expected 4", obs.size()); end
        for (int i = 0; i < obs.size() && i < 4; i++) begin
            n_cmp++;
            if (obs[i].data !== DW'(1 + i) || obs[i].last !== (i == 3) || obs[i].src !== 1'b1) begin
                n_fail++;
                $display("FAIL trunc_beat%0d: got d=%0d l=%b s=%b expected d=%0d l=%b s=1",
                         i, obs[i].data, obs[i].last, obs[i].src, 1 + i, i == 3);
            end
        end
        n_cmp++; if (n_pulse !== 1) begin n_fail++; $display("FAIL trunc_pulse_count: got %0d expected 1", n_pulse); end
        if (obs.size() == 4) begin
            n_cmp++;
            if (pulse_cyc !== int'(obs[3].cyc) + 1) begin
                n_fail++; $display("FAIL trunc_pulse_time: got cycle %0d expected %0d", pulse_cyc, obs[3].cyc + 1);
            end
        end
        n_cmp++; if (frame_cnt !== CW'(1)) begin n_fail++; $display("FAIL trunc_frame_cnt: got %0d expected 1", frame_cnt); end
    endtask

    task automatic test_enable_reset();
        int guard;
        do_reset();
        push_frame(0, 3, 1, 1'b0, 0);
        push_frame(0, 3, 4, 1'b0, 0);
        guard = 0;
        while (obs.size() < 1 && guard < 10) begin drive(); advance(); guard++; end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin drive(); advance(); end
        drive();
        n_cmp++; if (obs.size() !== 3) begin n_fail++; $display("FAIL en_frame_done: got %0d beats expected 3", obs.size()); end
        n_cmp++; if (q0.size() !== 3) begin n_fail++; $display("FAIL en_no_grant: got %0d beats left expected 3", q0.size()); end
        n_cmp++; if (m_TVALID !== 1'b0 || s0_TREADY !== 1'b0 || s0_TVALID !== 1'b1) begin n_fail++;
            $display("FAIL en_hold_idle: got valid=%b ready=%b svalid=%b expected 0/0/1", m_TVALID, s0_TREADY, s0_TVALID); end
        n_cmp++; if (frame_cnt !== CW'(1)) begin n_fail++; $display("FAIL en_frame_cnt: got %0d expected 1", frame_cnt); end
        advance();
        enable = 1'b1;
        guard = 0;
        while (obs.size() < 4 && guard < 10) begin drive(); advance(); guard++; end
        n_cmp++; if (obs.size() !== 4) begin n_fail++; $display("FAIL en_regrant: got %0d beats expected 4", obs.size()); end
        resetn = 1'b0;
        drive(); advance();
        resetn = 1'b1;
        q0.delete();
        drive();
        n_cmp++; if (m_TVALID !== 1'b0 || s0_TREADY !== 1'b0 || grant !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_idle: got valid=%b ready=%b grant=%b expected 0/0/0", m_TVALID, s0_TREADY, grant); end
        n_cmp++; if (frame_cnt !== '0) begin n_fail++; $display("FAIL rst_mid_frame_cnt: got %0d expected 0", frame_cnt); end
        advance();
    endtask

    task automatic test_saturation();
        int guard;
        do_reset();
        for (int i = 0; i < 17; i++) push_frame(0, 1, i, 1'b0, 0);
        guard = 0;
        while (q0.size() > 0 && guard < 100) begin drive(); advance(); guard++; end
        drive();
        n_cmp++; if (obs.size() !== 17) begin n_fail++; $display("FAIL sat_count: got %0d expected 17", obs.size()); end
        n_cmp++; if (frame_cnt !== {CW{1'b1}}) begin n_fail++; $display("FAIL sat_frame_cnt: got %0d expected %0d", frame_cnt, (1 << CW) - 1); end
        advance();
    endtask

    task automatic test_random();
        int guard, n_trunc, len;
        beat_t e;
        do_reset();
        rdy_mode = 2; rnd_valid = 1'b1;
        n_trunc = 0;
        for (int f = 0; f < 7; f++) begin
            for (int s = 0; s < 2; s++) begin
                len = $urandom_range(1, 7);
                if (len > MAXB) n_trunc++;
                push_frame(s, len, 0, 1'b1, 0);
            end
        end
        guard = 0;
        while ((q0.size() > 0 || q1.size() > 0) && guard < 1500) begin drive(); advance(); guard++; end
        drive(); advance();
        n_cmp++; if (q0.size() + q1.size() !== 0) begin n_fail++; $display("FAIL rand_timeout: got %0d beats left expected 0", q0.size() + q1.size()); end
        foreach (obs[i]) begin
            n_cmp++;
            if ((obs[i].src ? exp1.size() : exp0.size()) == 0) begin
                n_fail++; $display("FAIL rand_extra_beat%0d: got beat from src %b expected none", i, obs[i].src);
            end else begin
                e = obs[i].src ? exp1.pop_front() : exp0.pop_front();
                if (obs[i].data !== e.data || obs[i].user !== e.user || obs[i].last !== e.last) begin
                    n_fail++;
                    $display("FAIL rand_beat%0d: got s=%b d=%0d u=%0d l=%b expected d=%0d u=%0d l=%b",
                             i, obs[i].src, obs[i].data, obs[i].user, obs[i].last, e.data, e.user, e.last);
                end
            end
        end
        n_cmp++; if (exp0.size() + exp1.size() !== 0) begin n_fail++; $display("FAIL rand_missing: got %0d beats unseen expected 0", exp0.size() + exp1.size()); end
        n_cmp++; if (n_pulse !== n_trunc) begin n_fail++; $display("FAIL rand_trunc: got %0d pulses expected %0d", n_pulse, n_trunc); end
        n_cmp++; if (frame_cnt !== CW'(14)) begin n_fail++; $display("FAIL rand_frame_cnt: got %0d expected 14", frame_cnt); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; n_pulse = 0; pulse_cyc = -1; cyc = 0;
        rdy_mode = 0; rnd_valid = 1'b0;
        resetn = 1'b0; enable = 1'b0; m_TREADY = 1'b0;
        s0_TDATA = '0; s0_TUSER = '0; s0_TLAST = 1'b0; s0_TVALID = 1'b0;
        s1_TDATA = '0; s1_TUSER = '0; s1_TLAST = 1'b0; s1_TVALID = 1'b0;
        @(negedge tb_clk);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_truncation();
        test_enable_reset();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
